// File: rtl/uart_receiver.sv
// UART receive stage: 16x-oversampled 8E1 frame recovery with parity and framing
// error reporting, one-cycle valid strobe per received byte.
module uart_receiver #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Rx_EN,
    input  logic       RxD,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR,
    output logic       Rx_BUSY
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    // Divider rounds to nearest so the table matches the nominal baud values.
    function automatic int calc_div(input int baud);
        return (CLK_FREQ + baud * OVERSAMPLE / 2) / (baud * OVERSAMPLE);
    endfunction

    localparam logic [14:0] DIV_TABLE [8] = '{
        15'(calc_div(300)),   15'(calc_div(1200)),  15'(calc_div(4800)),  15'(calc_div(9600)),
        15'(calc_div(19200)), 15'(calc_div(38400)), 15'(calc_div(57600)), 15'(calc_div(115200))
    };

    state_t      state, state_next;
    logic        rx_meta, rx_sync, rx_prev;
    logic [14:0] div, tick_cnt;
    logic [3:0]  sample_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        parity_bit;
    logic        tick, start_edge, mid_start, bit_end, frame_done;

    // A falling edge needs rx_prev high, so after a break the line must return
    // high before the receiver can re-arm.
    assign start_edge = Rx_EN && rx_prev && !rx_sync;
    assign tick       = (state != IDLE) && (tick_cnt == div - 15'd1);
    assign mid_start  = tick && (sample_cnt == 4'd7);
    assign bit_end    = tick && (sample_cnt == 4'd15);
    assign frame_done = Rx_EN && (state == STOP) && bit_end;
    assign Rx_BUSY    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: state_next gets its default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_edge) state_next = START;
            START:   if (mid_start) state_next = rx_sync ? IDLE : DATA;
            DATA:    if (bit_end && bit_idx == 3'd7) state_next = PARITY;
            PARITY:  if (bit_end) state_next = STOP;
            STOP:    if (bit_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (!Rx_EN) state_next = IDLE;
    end

    // NOTE: all registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            div        <= DIV_TABLE[0];
            tick_cnt   <= '0;
            sample_cnt <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            parity_bit <= 1'b0;
            Rx_DATA    <= '0;
            Rx_VALID   <= 1'b0;
            Rx_PERROR  <= 1'b0;
            Rx_FERROR  <= 1'b0;
        end else begin
            rx_meta  <= RxD;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            Rx_VALID <= 1'b0;

            if (state == IDLE) begin
                tick_cnt   <= '0;
                sample_cnt <= '0;
                bit_idx    <= '0;
                if (start_edge) div <= DIV_TABLE[baud_select];
            end else if (tick) begin
                tick_cnt   <= '0;
                // Realign the 16-tick bit window to the middle of the start bit.
                sample_cnt <= (state == START && mid_start) ? 4'd0 : sample_cnt + 4'd1;
                if (state == DATA && bit_end) begin
                    shift   <= {rx_sync, shift[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                end
                if (state == PARITY && bit_end) parity_bit <= rx_sync;
            end else begin
                tick_cnt <= tick_cnt + 15'd1;
            end

            if (frame_done) begin
                Rx_VALID  <= 1'b1;
                Rx_DATA   <= shift;
                Rx_PERROR <= ^{shift, parity_bit};
                Rx_FERROR <= ~rx_sync;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: bench-driven 8E1 frames, a queue-based
// expected-result model checked every cycle, plus literal spot checks.
module tb_uart_receiver;

    localparam int CLK_FREQ = 3_686_400;

    logic       clk = 1'b0;
    logic       reset, Rx_EN, RxD;
    logic [2:0] baud_select;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_BUSY;

    uart_receiver #(.CLK_FREQ(CLK_FREQ), .OVERSAMPLE(16)) dut (
        .clk(clk), .reset(reset), .baud_select(baud_select), .Rx_EN(Rx_EN), .RxD(RxD),
        .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID), .Rx_PERROR(Rx_PERROR),
        .Rx_FERROR(Rx_FERROR), .Rx_BUSY(Rx_BUSY)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } frame_t;

    frame_t     exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] hold_data = 8'h00;
    logic       hold_perr = 1'b0;
    logic       hold_ferr = 1'b0;
    logic       prev_valid = 1'b0;
    logic       rst_at_edge = 1'b1;
    logic [7:0] stream [3] = '{8'h55, 8'hCC, 8'h89};

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bit time in clocks, straight from the line rate.
    function automatic int bit_clks(input logic [2:0] sel);
        int baud;
        case (sel)
            3'd0: baud = 300;    3'd1: baud = 1200;  3'd2: baud = 4800;  3'd3: baud = 9600;
            3'd4: baud = 19200;  3'd5: baud = 38400; 3'd6: baud = 57600; default: baud = 115200;
        endcase
        return CLK_FREQ / baud;
    endfunction

    // abort_mode: 0 full frame, 1 reset at mid data bit 4, 2 Rx_EN low at mid data bit 4.
    task automatic send_frame(input logic [7:0] d, input logic [2:0] sel, input logic flip,
                              input logic stop, input int abort_mode);
        int     bc;
        frame_t f;
        bc = bit_clks(sel);
        baud_select = sel;
        RxD = 1'b0;
        clks(bc);
        baud_select = ~sel;
        for (int i = 0; i < 8; i++) begin
            RxD = d[i];
            if (abort_mode != 0 && i == 4) begin
                clks(bc / 2);
                RxD = 1'b1;
                if (abort_mode == 1) begin
                    reset = 1'b1;
                    clks(3);
                    check("abort_reset_data", 32'(Rx_DATA), 32'h00);
                    check("abort_reset_busy", 32'(Rx_BUSY), 32'h0);
                    check("abort_reset_perr", 32'(Rx_PERROR), 32'h0);
                    reset = 1'b0;
                    clks(2);
                end else begin
                    Rx_EN = 1'b0;
                    @(posedge clk);
                    @(negedge clk);
                    check("abort_en_busy", 32'(Rx_BUSY), 32'h0);
                    clks(20);
                    Rx_EN = 1'b1;
                    clks(2);
                end
                return;
            end
            clks(bc);
        end
        RxD = (^d) ^ flip;
        clks(bc);
        f.data = d;
        f.perr = flip;
        f.ferr = ~stop;
        exp_q.push_back(f);
        RxD = stop;
        clks(bc);
    endtask

    task automatic wait_drain(input int limit);
        int i = 0;
        while (exp_q.size() != 0 && i < limit) begin
            clks(1);
            i++;
        end
        check("frame_received", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    always @(posedge clk) rst_at_edge <= reset;

    // Every cycle: a strobe must match the oldest pending frame; otherwise the
    // outputs must hold the last delivered (or reset) values.
    always @(negedge clk) begin
        frame_t f;
        if (rst_at_edge) begin
            check("valid_in_reset", 32'(Rx_VALID), 32'h0);
            check("data_in_reset", 32'(Rx_DATA), 32'h00);
            check("busy_in_reset", 32'(Rx_BUSY), 32'h0);
            hold_data = 8'h00;
            hold_perr = 1'b0;
            hold_ferr = 1'b0;
        end else if (Rx_VALID) begin
            check("valid_width", 32'(prev_valid), 32'h0);
            check("valid_expected", 32'(exp_q.size() > 0), 32'h1);
            if (exp_q.size() > 0) begin
                f = exp_q.pop_front();
                check("frame_data", 32'(Rx_DATA), 32'(f.data));
                check("frame_perr", 32'(Rx_PERROR), 32'(f.perr));
                check("frame_ferr", 32'(Rx_FERROR), 32'(f.ferr));
                hold_data = f.data;
                hold_perr = f.perr;
                hold_ferr = f.ferr;
            end
        end else begin
            check("hold_data", 32'(Rx_DATA), 32'(hold_data));
            check("hold_perr", 32'(Rx_PERROR), 32'(hold_perr));
            check("hold_ferr", 32'(Rx_FERROR), 32'(hold_ferr));
        end
        prev_valid = Rx_VALID;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        Rx_EN = 1'b1;
        RxD = 1'b1;
        baud_select = 3'd0;
        clks(4);
        check("reset_valid", 32'(Rx_VALID), 32'h0);
        check("reset_data", 32'(Rx_DATA), 32'h00);
        check("reset_perr", 32'(Rx_PERROR), 32'h0);
        check("reset_ferr", 32'(Rx_FERROR), 32'h0);
        check("reset_busy", 32'(Rx_BUSY), 32'h0);
        reset = 1'b0;
        clks(4);

        // Single frame at 9600 baud.
        send_frame(8'hAA, 3'b011, 1'b0, 1'b1, 0);
        wait_drain(200);
        check("t1_data", 32'(Rx_DATA), 32'hAA);
        check("t1_perr", 32'(Rx_PERROR), 32'h0);
        check("t1_ferr", 32'(Rx_FERROR), 32'h0);

        // Back-to-back stream at 115200, then all-zero / all-one bytes at 19200.
        foreach (stream[i]) send_frame(stream[i], 3'b111, 1'b0, 1'b1, 0);
        wait_drain(200);
        check("t2_last_data", 32'(Rx_DATA), 32'h89);
        send_frame(8'h00, 3'b100, 1'b0, 1'b1, 0);
        send_frame(8'hFF, 3'b100, 1'b0, 1'b1, 0);
        wait_drain(200);
        check("t2_ff_data", 32'(Rx_DATA), 32'hFF);
        check("t2_ff_perr", 32'(Rx_PERROR), 32'h0);

        // Inverted parity bit at 38400.
        send_frame(8'h89, 3'b101, 1'b1, 1'b1, 0);
        wait_drain(200);
        check("t3_data", 32'(Rx_DATA), 32'h89);
        check("t3_perr", 32'(Rx_PERROR), 32'h1);
        check("t3_ferr", 32'(Rx_FERROR), 32'h0);

        // Stop bit low, line held low two more bit times, then released.
        send_frame(8'h55, 3'b101, 1'b0, 1'b0, 0);
        clks(2 * 96);
        wait_drain(200);
        check("t4_data", 32'(Rx_DATA), 32'h55);
        check("t4_ferr", 32'(Rx_FERROR), 32'h1);
        check("t4_perr", 32'(Rx_PERROR), 32'h0);
        RxD = 1'b1;
        clks(3 * 96);
        check("t4_busy_after_break", 32'(Rx_BUSY), 32'h0);

        // Four-tick glitch at 300 baud (768 clocks per tick here).
        baud_select = 3'b000;
        RxD = 1'b0;
        clks(3000);
        check("t5_busy_in_glitch", 32'(Rx_BUSY), 32'h1);
        clks(72);
        RxD = 1'b1;
        clks(3072 + 40);
        check("t5_busy_after_mid_start", 32'(Rx_BUSY), 32'h0);
        check("t5_data_unchanged", 32'(Rx_DATA), 32'h55);

        // Mid-frame reset, then a clean frame.
        send_frame(8'hCC, 3'b110, 1'b0, 1'b1, 1);
        send_frame(8'hCC, 3'b110, 1'b0, 1'b1, 0);
        wait_drain(200);
        check("t6_reset_recover_data", 32'(Rx_DATA), 32'hCC);

        // Mid-frame enable drop, then a clean frame.
        send_frame(8'hCC, 3'b110, 1'b0, 1'b1, 2);
        check("t6_en_hold_data", 32'(Rx_DATA), 32'hCC);
        check("t6_en_hold_ferr", 32'(Rx_FERROR), 32'h0);
        send_frame(8'hCC, 3'b110, 1'b0, 1'b1, 0);
        wait_drain(200);
        check("t6_en_recover_data", 32'(Rx_DATA), 32'hCC);
        check("t6_en_recover_perr", 32'(Rx_PERROR), 32'h0);

        clks(50);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
